// File: rtl/os_pkg.sv
// Shared symbol constants, ordered-set encodings and latched-field type
// for the Gen1 ordered-set generator.
package os_pkg;

    localparam int SYM_W = 8;

    localparam logic [7:0] K_COM    = 8'hBC;
    localparam logic [7:0] K_PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID   = 8'h4A;
    localparam logic [7:0] TS2_ID   = 8'h45;
    localparam logic [7:0] IDLE_SYM = 8'h00;

    typedef enum logic [1:0] {
        OS_TS1  = 2'b00,
        OS_TS2  = 2'b01,
        OS_IDLE = 2'b10,
        OS_RSVD = 2'b11
    } osType_t;

    // LaneNumber 1x also means PAD; only LANE_SEQ selects the per-lane index.
    localparam logic [1:0] LANE_PAD = 2'b00;
    localparam logic [1:0] LANE_SEQ = 2'b01;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } osState_t;

    typedef struct packed {
        osType_t    osType;
        logic [1:0] laneNumber;
        logic [7:0] linkNumber;
        logic [2:0] rate;
        logic       loopback;
    } osFields_t;

    localparam logic [3:0] LAST_SYM = 4'd15;

    // Rate ID: one bit per supported generation 1..rate, with rate clamped to 1..5.
    function automatic logic [7:0] rateId(input logic [2:0] rate);
        logic [2:0] top;
        rateId = '0;
        if (rate == 3'd0)
            top = 3'd1;
        else if (rate > 3'd5)
            top = 3'd5;
        else
            top = rate;
        for (int g = 1; g <= 5; g++) begin
            if (3'(g) <= top)
                rateId[g] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/os_symbol_sel.sv
// Combinational symbol lookup for one lane: returns {K, symbol} for the
// given latched fields, symbol index and lane index.
module os_symbol_sel #(
    parameter logic [7:0] NFTS          = 8'hFF,
    parameter int         LINK_PAD_ZERO = 1
) (
    input  os_pkg::osFields_t fields,
    input  logic [3:0]        symIndex,
    input  logic [7:0]        laneIndex,
    output logic              symK,
    output logic [7:0]        symData
);
    import os_pkg::*;

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        symK    = 1'b0;
        symData = IDLE_SYM;
        if (fields.osType != OS_IDLE) begin
            case (symIndex)
                4'd0: begin
                    symK    = 1'b1;
                    symData = K_COM;
                end
                4'd1: begin
                    if ((LINK_PAD_ZERO != 0) && (fields.linkNumber == 8'd0)) begin
                        symK    = 1'b1;
                        symData = K_PAD;
                    end else begin
                        symData = fields.linkNumber;
                    end
                end
                4'd2: begin
                    if (fields.laneNumber == LANE_SEQ) begin
                        symData = laneIndex;
                    end else begin
                        symK    = 1'b1;
                        symData = K_PAD;
                    end
                end
                4'd3: symData = NFTS;
                4'd4: symData = rateId(fields.rate);
                4'd5: symData = {5'b0, fields.loopback, 2'b00};
                default: symData = (fields.osType == OS_TS2) ? TS2_ID : TS1_ID;
            endcase
        end
    end

endmodule

// File: rtl/os_generator.sv
// Gen1 TS1/TS2/IDLE ordered-set generator: 16 symbols per set on all lanes in
// parallel, Start/Busy/Finish handshake toward the TX LTSSM, registered outputs.
module os_generator #(
    parameter int         LANESNUMBER   = 16,
    parameter int         PIPEWIDTH     = 8,
    parameter logic [7:0] NFTS          = 8'hFF,
    parameter int         LINK_PAD_ZERO = 1
) (
    input  logic                             Pclk,
    input  logic                             Reset,
    input  logic                             OSGeneratorStart,
    input  logic [1:0]                       OSType,
    input  logic [1:0]                       LaneNumber,
    input  logic [7:0]                       LinkNumber,
    input  logic [2:0]                       Rate,
    input  logic                             Loopback,
    output logic                             OSGeneratorBusy,
    output logic                             OSGeneratorFinish,
    output logic [PIPEWIDTH*LANESNUMBER-1:0] OSData,
    output logic [LANESNUMBER-1:0]           OSDataK,
    output logic                             OSValid
);
    import os_pkg::*;

    osState_t   state, nextState;
    logic [3:0] symIdx, nextIdx;
    osFields_t  fields, nextFields;
    logic       nextSend;
    logic       nextFinish;

    logic [PIPEWIDTH*LANESNUMBER-1:0] laneData;
    logic [LANESNUMBER-1:0]           laneK;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            state  <= S_IDLE;
            symIdx <= '0;
            fields <= '0;
        end else begin
            state  <= nextState;
            symIdx <= nextIdx;
            fields <= nextFields;
        end
    end

    always_comb begin
        nextState  = state;
        nextIdx    = symIdx;
        nextFields = fields;
        case (state)
            S_IDLE: begin
                if (OSGeneratorStart && !OSGeneratorBusy && (OSType != OS_RSVD)) begin
                    nextState  = S_SEND;
                    nextIdx    = '0;
                    nextFields = '{osType:     osType_t'(OSType),
                                   laneNumber: LaneNumber,
                                   linkNumber: LinkNumber,
                                   rate:       Rate,
                                   loopback:   Loopback};
                end
            end
            S_SEND: begin
                if (symIdx == LAST_SYM) begin
                    nextState = S_IDLE;
                    nextIdx   = '0;
                end else begin
                    nextIdx = symIdx + 4'd1;
                end
            end
            default: nextState = S_IDLE;
        endcase
        nextSend   = (nextState == S_SEND);
        nextFinish = nextSend && (nextIdx == LAST_SYM);
    end

    // Symbols are looked up from next-cycle fields/index so the output
    // registers present symbol 0 on the cycle right after Start is sampled.
    for (genvar i = 0; i < LANESNUMBER; i++) begin : gLane
        logic [SYM_W-1:0] sym;

        os_symbol_sel #(
            .NFTS          (NFTS),
            .LINK_PAD_ZERO (LINK_PAD_ZERO)
        ) uSymbolSel (
            .fields    (nextFields),
            .symIndex  (nextIdx),
            .laneIndex (8'(i)),
            .symK      (laneK[i]),
            .symData   (sym)
        );

        assign laneData[PIPEWIDTH*i +: PIPEWIDTH] = sym;
    end

    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            OSGeneratorBusy   <= 1'b0;
            OSGeneratorFinish <= 1'b0;
            OSValid           <= 1'b0;
            OSData            <= '0;
            OSDataK           <= '0;
        end else begin
            OSGeneratorBusy   <= nextSend;
            OSGeneratorFinish <= nextFinish;
            OSValid           <= nextSend;
            OSData            <= nextSend ? laneData : '0;
            OSDataK           <= nextSend ? laneK : '0;
        end
    end

endmodule
